// File: rtl/repeat_counter_pkg.sv
// Shared constants and helpers for the repeat counter.
// Direction encodings and the rep_idx width rule.
package repeat_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int rw_of(input int rep);
    int w;
    w = $clog2(rep);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/repeat_prescaler.sv
// Hold-group position tracker for the repeat counter.
// Emits an advance strobe on the last enabled cycle of each group.
module repeat_prescaler
  import repeat_counter_pkg::*;
#(
  parameter int REPEAT = 3,
  parameter int RW     = rw_of(REPEAT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [RW-1:0] rep_idx,
  output logic          last_rep,
  output logic          adv
);

  localparam logic [RW-1:0] LAST = RW'(REPEAT - 1);

  assign last_rep = (rep_idx == LAST);
  // a clear (load) takes priority over advancing
  assign adv      = en & ~clr & last_rep;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rep_idx <= '0;
    end else if (clr) begin
      rep_idx <= '0;
    end else if (en) begin
      rep_idx <= last_rep ? '0 : rep_idx + 1'b1;
    end
  end

endmodule

// File: rtl/repeat_counter.sv
// Repeat counter: each value held REPEAT enabled cycles,
// with up/down, saturating load and step/wrap pulses.
module repeat_counter
  import repeat_counter_pkg::*;
#(
  parameter  int WIDTH     = 2,
  parameter  int REPEAT    = 3,
  parameter  int MAX_COUNT = 3,
  localparam int RW        = rw_of(REPEAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [RW-1:0]    rep_idx,
  output logic             last_rep,
  output logic             step,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

  logic             adv;
  logic [WIDTH-1:0] nxt;
  logic             nwrap;
  logic [WIDTH-1:0] sat;

  repeat_prescaler #(
    .REPEAT (REPEAT),
    .RW     (RW)
  ) u_pre (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .rep_idx  (rep_idx),
    .last_rep (last_rep),
    .adv      (adv)
  );

  assign sat = (load_val > MAXV) ? MAXV : load_val;

  // out-of-range state recovers to 0 in either direction
  always_comb begin
    nxt   = count;
    nwrap = 1'b0;
    if (count > MAXV) begin
      nxt   = '0;
      nwrap = 1'b1;
    end else if (up_dn == DIR_UP) begin
      if (count == MAXV) begin
        nxt   = '0;
        nwrap = 1'b1;
      end else begin
        nxt = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        nxt   = MAXV;
        nwrap = 1'b1;
      end else begin
        nxt = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= sat;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else if (adv) begin
      count <= nxt;
      step  <= 1'b1;
      wrap  <= nwrap;
    end else begin
      step  <= 1'b0;
      wrap  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_repeat_counter.sv
// Bench for repeat_counter: four parameterisations checked
// against an arithmetic model every cycle plus directed literals.
module tb_repeat_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [4];
  logic       en  [4];
  logic       ud  [4];
  logic       ld  [4];
  logic [3:0] lv  [4];

  logic [1:0] c0, c1, c2;
  logic [3:0] c3;
  logic [1:0] r0, r2;
  logic [0:0] r1, r3;
  logic       lr0, lr1, lr2, lr3;
  logic       st0, st1, st2, st3;
  logic       wr0, wr1, wr2, wr3;

  repeat_counter u0 (
    .clk(clk), .rst(rst[0]), .en(en[0]), .up_dn(ud[0]),
    .load(ld[0]), .load_val(lv[0][1:0]), .count(c0),
    .rep_idx(r0), .last_rep(lr0), .step(st0), .wrap(wr0)
  );

  repeat_counter #(.WIDTH(2), .REPEAT(2), .MAX_COUNT(2)) u1 (
    .clk(clk), .rst(rst[1]), .en(en[1]), .up_dn(ud[1]),
    .load(ld[1]), .load_val(lv[1][1:0]), .count(c1),
    .rep_idx(r1), .last_rep(lr1), .step(st1), .wrap(wr1)
  );

  repeat_counter #(.WIDTH(2), .REPEAT(3), .MAX_COUNT(2)) u2 (
    .clk(clk), .rst(rst[2]), .en(en[2]), .up_dn(ud[2]),
    .load(ld[2]), .load_val(lv[2][1:0]), .count(c2),
    .rep_idx(r2), .last_rep(lr2), .step(st2), .wrap(wr2)
  );

  repeat_counter #(.WIDTH(4), .REPEAT(1), .MAX_COUNT(9)) u3 (
    .clk(clk), .rst(rst[3]), .en(en[3]), .up_dn(ud[3]),
    .load(ld[3]), .load_val(lv[3]), .count(c3),
    .rep_idx(r3), .last_rep(lr3), .step(st3), .wrap(wr3)
  );

  int P_REP [4] = '{3, 2, 3, 1};
  int P_MAX [4] = '{3, 2, 2, 9};

  int mc [4];
  int mp [4];
  int ms [4];
  int mw [4];

  int checks = 0;
  int errors = 0;
  bit live   = 1'b0;

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d",
               nm, i, act, exp);
    end
  endtask

  // model: position counts enabled cycles in the group,
  // values move modulo MAX+1
  task automatic upd(input int i);
    int m;
    int r;
    m = P_MAX[i];
    r = P_REP[i];
    if (!rst[i]) begin
      mc[i] = 0; mp[i] = 0; ms[i] = 0; mw[i] = 0;
    end else if (ld[i]) begin
      mc[i] = (int'(lv[i]) > m) ? m : int'(lv[i]);
      mp[i] = 0; ms[i] = 0; mw[i] = 0;
    end else if (en[i]) begin
      if (mp[i] + 1 < r) begin
        mp[i]++; ms[i] = 0; mw[i] = 0;
      end else begin
        mp[i] = 0;
        ms[i] = 1;
        if (ud[i]) begin
          mw[i] = (mc[i] == m) ? 1 : 0;
          mc[i] = (mc[i] + 1) % (m + 1);
        end else begin
          mw[i] = (mc[i] == 0) ? 1 : 0;
          mc[i] = (mc[i] + m) % (m + 1);
        end
      end
    end else begin
      ms[i] = 0; mw[i] = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int i = 0; i < 4; i++) upd(i);
    @(negedge clk);
  endtask

  task automatic cmp(input int i, input logic [31:0] c,
                     input logic [31:0] r, input logic lr,
                     input logic s, input logic w);
    chk("count", i, c, mc[i]);
    chk("rep_idx", i, r, mp[i]);
    chk("last_rep", i, {31'd0, lr},
        (mp[i] == P_REP[i] - 1) ? 1 : 0);
    chk("step", i, {31'd0, s}, ms[i]);
    chk("wrap", i, {31'd0, w}, mw[i]);
  endtask

  always @(negedge clk) begin
    if (live) begin
      cmp(0, 32'(c0), 32'(r0), lr0, st0, wr0);
      cmp(1, 32'(c1), 32'(r1), lr1, st1, wr1);
      cmp(2, 32'(c2), 32'(r2), lr2, st2, wr2);
      cmp(3, 32'(c3), 32'(r3), lr3, st3, wr3);
    end
  end

  int s1 [14] = '{0,0,0,1,1,1,2,2,2,3,3,3,0,0};
  int s2 [9]  = '{0,0,2,2,1,1,0,0,2};
  int s6 [6]  = '{8,9,0,1,0,9};

  initial begin
    int nw;
    int ns;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ud[i] = 1'b1;
      ld[i] = 1'b0; lv[i] = 4'd0;
      mc[i] = 0; mp[i] = 0; ms[i] = 0; mw[i] = 0;
    end
    cyc();
    live = 1'b1;
    cyc();
    chk("rst_count", 0, 32'(c0), 0);
    chk("rst_rep", 0, 32'(r0), 0);
    chk("rst_lr3", 3, {31'd0, lr3}, 1);
    chk("rst_lr0", 0, {31'd0, lr0}, 0);
    for (int i = 0; i < 4; i++) rst[i] = 1'b1;

    en[0] = 1'b1; ud[0] = 1'b1;
    nw = 0; ns = 0;
    for (int k = 0; k < 14; k++) begin
      chk("t1_count", 0, 32'(c0), s1[k]);
      cyc();
      nw += int'(wr0);
      ns += int'(st0);
      if (k == 11) begin
        chk("t1_wrap_at0", 0, {31'd0, wr0}, 1);
        chk("t1_cnt_at0", 0, 32'(c0), 0);
      end
    end
    chk("t1_nwrap", 0, nw, 1);
    chk("t1_nstep", 0, ns, 4);
    en[0] = 1'b0;

    ud[1] = 1'b0; en[1] = 1'b1;
    nw = 0;
    for (int k = 0; k < 9; k++) begin
      chk("t2_count", 1, 32'(c1), s2[k]);
      if (k < 8) begin
        cyc();
        nw += int'(wr1);
      end
    end
    chk("t2_nwrap", 1, nw, 2);
    en[1] = 1'b0;

    en[2] = 1'b1;
    cyc();
    chk("t3_rep_pre", 2, 32'(r2), 1);
    ld[2] = 1'b1; lv[2] = 4'd3;
    cyc();
    chk("t3_sat", 2, 32'(c2), 2);
    chk("t3_rep", 2, 32'(r2), 0);
    chk("t3_step", 2, {31'd0, st2}, 0);
    ld[2] = 1'b0;
    cyc();
    cyc();
    chk("t3_hold", 2, 32'(c2), 2);
    cyc();
    chk("t3_adv", 2, 32'(c2), 0);
    chk("t3_wrap", 2, {31'd0, wr2}, 1);
    en[2] = 1'b0;

    rst[0] = 1'b0;
    cyc();
    rst[0] = 1'b1; en[0] = 1'b1; ud[0] = 1'b1;
    repeat (4) cyc();
    chk("t4_cnt", 0, 32'(c0), 1);
    chk("t4_rep", 0, 32'(r0), 1);
    en[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t4_frz_c", 0, 32'(c0), 1);
      chk("t4_frz_r", 0, 32'(r0), 1);
      chk("t4_frz_s", 0, {31'd0, st0 | wr0}, 0);
    end
    en[0] = 1'b1;
    cyc();
    chk("t4_res1", 0, 32'(c0), 1);
    cyc();
    chk("t4_res2", 0, 32'(c0), 2);

    repeat (5) cyc();
    chk("t5_cnt", 0, 32'(c0), 3);
    chk("t5_rep", 0, 32'(r0), 2);
    rst[0] = 1'b0;
    #1;
    chk("t5_mid_c", 0, 32'(c0), 3);
    chk("t5_mid_r", 0, 32'(r0), 2);
    cyc();
    chk("t5_rc", 0, 32'(c0), 0);
    chk("t5_rr", 0, 32'(r0), 0);
    chk("t5_rs", 0, {31'd0, st0}, 0);
    chk("t5_rw", 0, {31'd0, wr0}, 0);
    rst[0] = 1'b1; en[0] = 1'b0;

    ld[3] = 1'b1; lv[3] = 4'd8;
    cyc();
    ld[3] = 1'b0; en[3] = 1'b1; ud[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t6_count", 3, 32'(c3), s6[k]);
      chk("t6_lr", 3, {31'd0, lr3}, 1);
      if (k == 3) ud[3] = 1'b0;
      if (k < 5) cyc();
    end
    en[3] = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
